// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan driver.
// Segment patterns are stored active-low, bit0 = a ... bit6 = g.
package seg7_pkg;

    typedef enum logic [1:0] {
        SHOW    = 2'd0,
        BLANK   = 2'd1,
        ADVANCE = 2'd2
    } scan_state_t;

    // All segments dark in active-low form.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/hex_nibble_enc.sv
// Combinational hex nibble to 7-segment encoder with selectable pin polarity.
module hex_nibble_enc
    import seg7_pkg::*;
#(
    parameter int ACTIVE_LOW = 1
) (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = (ACTIVE_LOW != 0) ? SEG_TABLE[i_nibble] : ~SEG_TABLE[i_nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed NUM_DIGITS 7-segment driver with frame-synchronous double buffer,
// dead time between digits and registered pins. Optional: LEADING_ZERO_BLANK_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 4,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(REFRESH_DIV);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] TICK_CNT  = PRE_W'(REFRESH_DIV - 1);
    localparam logic [PRE_W-1:0] DEAD_LAST = PRE_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
    localparam logic             POL       = (ACTIVE_LOW != 0);
    localparam logic [6:0]       SEG_IDLE  = POL ? SEG_OFF : ~SEG_OFF;

    scan_state_t             r_state;
    logic [IDX_W-1:0]        r_index;
    logic [PRE_W-1:0]        r_presc;
    logic [4*NUM_DIGITS-1:0] r_sh_value;
    logic [NUM_DIGITS-1:0]   r_sh_dp;
    logic [NUM_DIGITS-1:0]   r_sh_blank;
    logic [4*NUM_DIGITS-1:0] r_disp_value;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic [NUM_DIGITS-1:0]   r_disp_blank;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_start;

    logic                    w_tick;
    logic                    w_wrap;
    logic                    w_show;
    logic                    w_lit;
    logic [3:0]              w_nibble;
    logic [6:0]              w_enc_seg;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic [NUM_DIGITS-1:0]   w_auto_blank;

    assign w_tick   = (r_presc == TICK_CNT);
    assign w_wrap   = (r_index == LAST_IDX);
    assign w_show   = (r_state == SHOW);
    assign w_lit    = w_show && !r_disp_blank[r_index];
    assign w_nibble = 4'(r_disp_value >> {r_index, 2'b00});
    assign w_onehot = NUM_DIGITS'(1) << r_index;

`ifdef LEADING_ZERO_BLANK_EN
    logic w_leading;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_auto_blank = '0;
        w_leading    = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (w_leading && (r_sh_value[4*k +: 4] == 4'h0)) begin
                w_auto_blank[k] = 1'b1;
            end else begin
                w_leading = 1'b0;
            end
        end
    end
`else
    assign w_auto_blank = '0;
`endif

    hex_nibble_enc #(
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_enc (
        .i_nibble (w_nibble),
        .o_seg    (w_enc_seg)
    );

    // NOTE: non-blocking assignments make every register sample pre-edge values; that is
    // what lets a load on the wrap cycle reach the display one frame later, untorn.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= SHOW;
            r_index       <= '0;
            r_presc       <= '0;
            // NOTE: the buffers are plain registers, so they take reset like any other state.
            // The live display starts unblanked showing zeros; the shadow starts fully blanked.
            r_sh_value    <= '0;
            r_sh_dp       <= '0;
            r_sh_blank    <= '1;
            r_disp_value  <= '0;
            r_disp_dp     <= '0;
            r_disp_blank  <= '0;
            r_seg         <= SEG_IDLE;
            r_dp          <= POL;
            r_an          <= {NUM_DIGITS{POL}};
            r_frame_start <= 1'b0;
        end else begin
            if (load) begin
                r_sh_value <= value;
                r_sh_dp    <= dp_in;
                r_sh_blank <= blank_in;
            end

            r_presc <= w_tick ? '0 : r_presc + 1'b1;

            case (r_state)
                SHOW: begin
                    if (w_tick) begin
                        r_state <= (DEAD_CYCLES == 0) ? ADVANCE : BLANK;
                    end
                end
                BLANK: begin
                    if (r_presc == DEAD_LAST) begin
                        r_state <= ADVANCE;
                    end
                end
                ADVANCE: begin
                    r_presc <= '0;
                    r_state <= SHOW;
                    r_index <= w_wrap ? '0 : r_index + 1'b1;
                    if (w_wrap) begin
                        r_disp_value <= r_sh_value;
                        r_disp_dp    <= r_sh_dp;
                        r_disp_blank <= r_sh_blank | w_auto_blank;
                    end
                end
                default: r_state <= SHOW;
            endcase

            // Pins follow the FSM register by one cycle.
            r_seg         <= w_lit ? w_enc_seg : SEG_IDLE;
            r_dp          <= (w_lit & r_disp_dp[r_index]) ^ POL;
            r_an          <= w_show ? (w_onehot ^ {NUM_DIGITS{POL}}) : {NUM_DIGITS{POL}};
            r_frame_start <= w_show && (r_index == '0) && (r_presc == '0);
        end
    end

    assign seg         = r_seg;
    assign dp          = r_dp;
    assign an          = r_an;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench: an active-low and an active-high instance share stimulus and are
// compared every cycle against a frame/phase arithmetic model of the scan.
module tb_seg7_scan_driver;

    localparam int ND     = 4;
    localparam int RD     = 8;
    localparam int DC     = 2;
    localparam int PERIOD = RD + DC + 1;
    localparam int FRAME  = PERIOD * ND;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       fs;
    } pins_t;

    // Active-low decode table, a at bit0.
    localparam logic [6:0] DECODE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [6:0] EXP_12AF [4] = '{7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001};
    localparam logic [6:0] EXP_3456 [4] = '{7'b0000010, 7'b0010010, 7'b0011001, 7'b0110000};
    localparam logic [6:0] EXP_9870 [4] = '{7'b1000000, 7'b1111000, 7'b0000000, 7'b0011000};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;

    logic [6:0]  seg, seg_h;
    logic        dp, dp_h;
    logic [3:0]  an, an_h;
    logic        frame_start, fs_h;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .DEAD_CYCLES(DC), .ACTIVE_LOW(1)) u_dut (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .blank_in(blank_in), .load(load),
        .seg(seg), .dp(dp), .an(an), .frame_start(frame_start)
    );

    seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .DEAD_CYCLES(DC), .ACTIVE_LOW(0)) u_dut_h (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .blank_in(blank_in), .load(load),
        .seg(seg_h), .dp(dp_h), .an(an_h), .frame_start(fs_h)
    );

    // Reference model: position in the scan is a plain cycle count since reset release.
    int          m_s;
    logic [15:0] m_sh_v, m_d_v;
    logic [3:0]  m_sh_dp, m_sh_bl, m_d_dp, m_d_bl;
    pins_t       m_exp;

    function automatic logic [3:0] lz_mask(input logic [15:0] v);
        logic [3:0] mask = '0;
`ifdef LEADING_ZERO_BLANK_EN
        int top = 0;
        for (int k = 0; k < ND; k++) if (v[4*k +: 4] != 4'h0) top = k;
        for (int k = 0; k < ND; k++) if (k > top) mask[k] = 1'b1;
`endif
        return mask;
    endfunction

    function automatic pins_t model_pins(input int s, input logic [15:0] v,
                                         input logic [3:0] dpm, input logic [3:0] bl);
        pins_t p = '0;
        int ph = s % PERIOD;
        int dg = (s / PERIOD) % ND;
        if (ph < RD) begin
            p.an = 4'(1 << dg);
            p.fs = (ph == 0) && (dg == 0);
            if (!bl[dg]) begin
                p.seg = ~DECODE[v[4*dg +: 4]];
                p.dp  = dpm[dg];
            end
        end
        return p;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_s     <= 0;
            m_sh_v  <= '0;  m_sh_dp <= '0;  m_sh_bl <= '1;
            m_d_v   <= '0;  m_d_dp  <= '0;  m_d_bl  <= '0;
            m_exp   <= '0;
        end else begin
            m_exp <= model_pins(m_s, m_d_v, m_d_dp, m_d_bl);
            if (m_s % FRAME == FRAME - 1) begin
                m_d_v  <= m_sh_v;
                m_d_dp <= m_sh_dp;
                m_d_bl <= m_sh_bl | lz_mask(m_sh_v);
            end
            if (load) begin
                m_sh_v  <= value;
                m_sh_dp <= dp_in;
                m_sh_bl <= blank_in;
            end
            m_s <= m_s + 1;
        end
    end

    logic [25:0] act_all, exp_all;
    assign act_all = {seg, dp, an, frame_start, seg_h, dp_h, an_h, fs_h};
    assign exp_all = {~m_exp.seg, ~m_exp.dp, ~m_exp.an, m_exp.fs, m_exp};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until the next edge will close scan position pos of a frame.
    task automatic align_to(input int pos);
        for (int i = 0; i < FRAME && (m_s % FRAME) != pos; i++) tick();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        value = v; dp_in = d; blank_in = b; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({seg, dp, an, frame_start} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
            errors++; $display("FAIL reset_lo got %h exp %h", {seg, dp, an, frame_start}, {7'h7F, 1'b1, 4'hF, 1'b0});
        end
        checks++;
        if ({seg_h, dp_h, an_h, fs_h} !== 13'h0) begin
            errors++; $display("FAIL reset_hi got %h exp 0", {seg_h, dp_h, an_h, fs_h});
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({frame_start, an, seg} !== {1'b1, 4'b1110, 7'b1000000}) begin
            errors++; $display("FAIL first_frame got %b exp %b", {frame_start, an, seg}, {1'b1, 4'b1110, 7'b1000000});
        end
        for (int i = 1; i < 2 * FRAME; i++) begin
            tick();
            checks++;
            if (act_all !== exp_all) begin
                errors++; $display("FAIL model_reset cyc %0d got %h exp %h", i, act_all, exp_all);
            end
            if (i == RD || i == PERIOD) begin
                checks++;
                if (an !== ((i == RD) ? 4'b1111 : 4'b1101)) begin
                    errors++; $display("FAIL digit_period cyc %0d got an %b", i, an);
                end
            end
        end
    endtask

    task automatic test_load_mid_frame();
        int f_load, s_out;
        align_to(20);
        f_load = m_s / FRAME;
        do_load(16'h12AF, 4'h0, 4'h0);
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            s_out = m_s - 1;
            checks++;
            if (act_all !== exp_all) begin
                errors++; $display("FAIL model_load cyc %0d got %h exp %h", i, act_all, exp_all);
            end
            if (s_out / FRAME == f_load + 1 && s_out % PERIOD == 0) begin
                int dg = (s_out % FRAME) / PERIOD;
                logic [3:0] e_an = ~(4'(1 << dg));
                checks++;
                if (seg !== EXP_12AF[dg] || an !== e_an) begin
                    errors++; $display("FAIL load_12af digit %0d got %b/%b exp %b/%b", dg, seg, an, EXP_12AF[dg], e_an);
                end
            end
        end
    endtask

    task automatic test_wrap_collision();
        int f_col, s_out, f, dg;
        align_to(20);
        do_load(16'h3456, 4'h0, 4'h0);
        align_to(FRAME - 1);
        f_col = m_s / FRAME;
        do_load(16'h9870, 4'h0, 4'h0);
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            s_out = m_s - 1;
            f = s_out / FRAME;
            dg = (s_out % FRAME) / PERIOD;
            checks++;
            if (act_all !== exp_all) begin
                errors++; $display("FAIL model_collision cyc %0d got %h exp %h", i, act_all, exp_all);
            end
            if ((f == f_col + 1 || f == f_col + 2) && s_out % PERIOD == 0) begin
                logic [6:0] e_seg = (f == f_col + 1) ? EXP_3456[dg] : EXP_9870[dg];
                checks++;
                if (seg !== e_seg) begin
                    errors++; $display("FAIL collision frame %0d digit %0d got %b exp %b", f - f_col, dg, seg, e_seg);
                end
            end
        end
    endtask

    task automatic test_blank_dp();
        int f_ld, s_out, dg;
        align_to(20);
        f_ld = m_s / FRAME;
        do_load(16'(($urandom() & 32'hFFFF) | 32'h0100), 4'b0001, 4'b0100);
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            s_out = m_s - 1;
            dg = (s_out % FRAME) / PERIOD;
            checks++;
            if (act_all !== exp_all) begin
                errors++; $display("FAIL model_blank cyc %0d got %h exp %h", i, act_all, exp_all);
            end
            if (s_out / FRAME == f_ld + 1 && s_out % PERIOD == 1) begin
                if (dg == 2) begin
                    checks++;
                    if ({an, seg, dp, an_h, seg_h} !== {4'b1011, 7'h7F, 1'b1, 4'b0100, 7'h00}) begin
                        errors++; $display("FAIL blank_digit2 got %h exp %h", {an, seg, dp, an_h, seg_h},
                                            {4'b1011, 7'h7F, 1'b1, 4'b0100, 7'h00});
                    end
                end else if (dg == 0) begin
                    checks++;
                    if ({dp, dp_h} !== 2'b01) begin
                        errors++; $display("FAIL dp_digit0 got %b exp 01", {dp, dp_h});
                    end
                end
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [15:0] vals [2] = '{16'h0005, 16'h0000};
        for (int t = 0; t < 2; t++) begin
            int f_ld, s_out, dg;
            align_to(20);
            f_ld = m_s / FRAME;
            do_load(vals[t], 4'h0, 4'h0);
            for (int i = 0; i < 2 * FRAME; i++) begin
                tick();
                s_out = m_s - 1;
                dg = (s_out % FRAME) / PERIOD;
                checks++;
                if (act_all !== exp_all) begin
                    errors++; $display("FAIL model_lzb cyc %0d got %h exp %h", i, act_all, exp_all);
                end
                if (s_out / FRAME == f_ld + 1 && s_out % PERIOD == 0) begin
                    logic [6:0] e_seg = (dg == 0) ? DECODE[vals[t][3:0]] : DECODE[0];
`ifdef LEADING_ZERO_BLANK_EN
                    if (dg != 0) e_seg = 7'h7F;
`endif
                    checks++;
                    if (seg !== e_seg) begin
                        errors++; $display("FAIL lzb val %h digit %0d got %b exp %b", vals[t], dg, seg, e_seg);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8 * FRAME; i++) begin
            if ($urandom_range(15) == 0) begin
                value = 16'($urandom()); dp_in = 4'($urandom()); blank_in = 4'($urandom()); load = 1'b1;
            end else begin
                load = 1'b0;
            end
            tick();
            checks++;
            if (act_all !== exp_all) begin
                errors++; $display("FAIL model_random cyc %0d got %h exp %h", i, act_all, exp_all);
            end
        end
        load = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        align_to(2 * PERIOD + RD);
        rst = 1'b1;
        value = 16'hBEEF; load = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if ({seg, dp, an, frame_start, seg_h, dp_h, an_h, fs_h} !== {7'h7F, 1'b1, 4'hF, 1'b0, 13'h0}) begin
            errors++; $display("FAIL reset_mid got %h exp %h", act_all, {7'h7F, 1'b1, 4'hF, 1'b0, 13'h0});
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({frame_start, an, seg} !== {1'b1, 4'b1110, 7'b1000000}) begin
            errors++; $display("FAIL restart got %b exp %b", {frame_start, an, seg}, {1'b1, 4'b1110, 7'b1000000});
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            checks++;
            if (act_all !== exp_all) begin
                errors++; $display("FAIL model_restart cyc %0d got %h exp %h", i, act_all, exp_all);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_mid_frame();
        test_wrap_collision();
        test_blank_dp();
        test_leading_zero();
        test_random();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
